// File: rtl/fir_job_sched.sv
// Two-requester job scheduler for a shared FIR datapath: arbitrates, streams samples in,
// waits for the datapath (with timeout), streams results out, then releases the grant.
module fir_job_sched #(
    parameter int SIGNAL_COUNT = 10,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [1:0]        in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_id,
    input  logic              out_ready,
    output logic [1:0]        fir_op,
    output logic [31:0]       fir_addr,
    output logic [DATA_W-1:0] fir_x,
    output logic              fir_load,
    input  logic [DATA_W-1:0] fir_y,
    input  logic              fir_done,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam int          CW     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] K_LAST = 32'(SIGNAL_COUNT - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;

    logic accept;
    logic timeout_hit;

    assign accept      = (state_q == S_LOAD) && in_valid[owner_q];
    assign timeout_hit = (state_q == S_COMPUTE) && !fir_done && (cnt_q == T_LAST);

    // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // On a tie the requester not served last wins.
                    owner_d = (req == 2'b11) ? ~last_q : req[1];
                    k_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        k_d = k_q + 32'd1;
                    end
                end
            end
            S_COMPUTE: begin
                if (fir_done) begin
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_READ;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = S_RELEASE;
                    end else begin
                        k_d = k_q + 32'd1;
                    end
                end
            end
            S_RELEASE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        fir_op = 2'b00;
        case (state_q)
            S_LOAD:    fir_op = 2'b01;
            S_COMPUTE: fir_op = 2'b10;
            S_READ:    fir_op = 2'b11;
            default:   fir_op = 2'b00;
        endcase
    end

    // Outputs are decoded from state so they are all at rest whenever the FSM is idle.
    assign gnt       = (state_q == S_LOAD || state_q == S_COMPUTE || state_q == S_READ)
                       ? {owner_q, ~owner_q} : 2'b00;
    assign busy      = (state_q != S_IDLE);
    assign err       = timeout_hit;
    assign in_ready  = (state_q == S_LOAD);
    assign fir_load  = accept;
    assign fir_x     = accept ? (owner_q ? in_data1 : in_data0) : '0;
    assign fir_addr  = (state_q == S_LOAD || state_q == S_READ) ? k_q : 32'd0;
    assign out_valid = (state_q == S_READ);
    assign out_data  = (state_q == S_READ) ? fir_y : '0;
    assign out_id    = (state_q == S_READ) && owner_q;
    assign out_last  = (state_q == S_READ) && (k_q == K_LAST);

endmodule

// File: tb/tb_fir_job_sched.sv
// Scoreboard bench for fir_job_sched: a behavioural datapath computes y = 3*x + 7 per index.
module tb_fir_job_sched;

    localparam int SC = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [1:0]    gnt;
    logic [DW-1:0] in_data0 = '0;
    logic [DW-1:0] in_data1 = '0;
    logic [1:0]    in_valid = 2'b00;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, out_id;
    logic          out_ready = 1'b1;
    logic [1:0]    fir_op;
    logic [31:0]   fir_addr;
    logic [DW-1:0] fir_x;
    logic          fir_load;
    logic [DW-1:0] fir_y;
    logic          fir_done = 1'b0;
    logic          busy, err;

    fir_job_sched #(.SIGNAL_COUNT(SC), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .in_data0(in_data0), .in_data1(in_data1), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_id(out_id),
        .out_ready(out_ready), .fir_op(fir_op), .fir_addr(fir_addr), .fir_x(fir_x),
        .fir_load(fir_load), .fir_y(fir_y), .fir_done(fir_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          id;
        int            idx;
        logic          last;
    } res_t;

    res_t          exp_q[$];
    logic [DW-1:0] src0[$];
    logic [DW-1:0] src1[$];
    int            gnt_exp[$];
    logic [DW-1:0] dp_mem [16];

    int errors = 0;
    int checks = 0;

    int done_delay = 5, cc = 0, stall_k = -1, stall_left = 0;
    int exp_k = 0, job_loads = 0, job_res = 0, grant_cnt = 0, err_cnt = 0;
    bit job_err = 0, gap0 = 0, tog = 0, acc0 = 0, acc1 = 0, prev_rel = 0;
    logic [1:0] prev_gnt = 2'b00;

    assign fir_y = dp_mem[fir_addr[3:0]] * 32'd3 + 32'd7;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string t);
        check({t, "_gnt"}, gnt, 0);
        check({t, "_fir_op"}, fir_op, 0);
        check({t, "_fir_addr"}, fir_addr, 0);
        check({t, "_fir_x"}, fir_x, 0);
        check({t, "_fir_load"}, fir_load, 0);
        check({t, "_in_ready"}, in_ready, 0);
        check({t, "_out_valid"}, out_valid, 0);
        check({t, "_out_last"}, out_last, 0);
        check({t, "_out_id"}, out_id, 0);
        check({t, "_out_data"}, out_data, 0);
        check({t, "_busy"}, busy, 0);
        check({t, "_err"}, err, 0);
    endtask

    task automatic queue_job(input int r, input int base, input bit results);
        for (int j = 0; j < SC; j++) begin
            if (r == 1) src1.push_back(DW'(base + j));
            else        src0.push_back(DW'(base + j));
            if (results)
                exp_q.push_back('{data: DW'((base + j) * 3 + 7), id: 1'(r), idx: j, last: (j == SC - 1)});
        end
        gnt_exp.push_back(r);
    endtask

    task automatic wait_drain(input string t, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || gnt_exp.size() != 0 || busy) && n < max) begin
            @(posedge clk); #2;
            n++;
        end
        check(t, exp_q.size() + gnt_exp.size() + int'(busy), 0);
    endtask

    task automatic run_job(input logic [1:0] m, input string t);
        int n = 0;
        @(posedge clk); #1;
        req = m;
        while (gnt == 2'b00 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check({t, "_granted"}, gnt != 2'b00, 1);
        req = 2'b00;
        wait_drain({t, "_drain"}, 400);
    endtask

    // Input driver: retires accepted samples and presents the next one just after each edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (acc0 && src0.size() != 0) void'(src0.pop_front());
            if (acc1 && src1.size() != 0) void'(src1.pop_front());
            acc0 = 0;
            acc1 = 0;
            tog  = ~tog;
            in_valid[0] = (src0.size() != 0) && (!gap0 || tog);
            in_data0    = (src0.size() != 0) ? src0[0] : '0;
            in_valid[1] = (src1.size() != 0);
            in_data1    = (src1.size() != 0) ? src1[0] : '0;
        end
    end

    // Monitor and datapath model, sampled mid-cycle.
    initial begin
        forever begin
            logic [DW-1:0] want;
            logic [1:0]    g_exp;
            @(negedge clk);
            if (out_valid && int'(fir_addr) == stall_k && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end

            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                g_exp = 2'b00;
                if (gnt_exp.size() != 0) g_exp = (gnt_exp.pop_front() == 1) ? 2'b10 : 2'b01;
                check("gnt_order", gnt, g_exp);
                check("gnt_first_op", fir_op, 2'b01);
                exp_k = 0; job_loads = 0; job_res = 0; job_err = 0;
                grant_cnt++;
            end

            if (fir_load) begin
                if (gnt[1]) want = (src1.size() != 0) ? src1[0] : '0;
                else        want = (src0.size() != 0) ? src0[0] : '0;
                check("load_addr", fir_addr, exp_k);
                check("load_x", fir_x, want);
                dp_mem[fir_addr[3:0]] = fir_x;
                exp_k++;
                job_loads++;
                if (gnt[1]) acc1 = 1; else acc0 = 1;
            end

            if (out_valid) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_id", out_id, exp_q[0].id);
                    check("out_last", out_last, exp_q[0].last);
                    check("out_addr", fir_addr, exp_q[0].idx);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        job_res++;
                    end
                end
            end

            if (prev_rel) check("release_one_cycle", busy, 0);
            if (busy && gnt == 2'b00) begin
                check("release_op", fir_op, 0);
                check("release_loads", job_loads, SC);
                check("release_results", job_res, job_err ? 0 : SC);
            end
            prev_rel = busy && gnt == 2'b00;

            if (err) err_cnt++;
            if (fir_op == 2'b10) begin
                cc++;
                if (err) begin
                    check("err_cycle", cc, TO);
                    job_err = 1;
                end
                fir_done = (done_delay > 0) && (cc >= done_delay);
            end else begin
                cc = 0;
                fir_done = 1'b0;
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) dp_mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Single job, gapless stream, grant latency of one cycle, req dropped mid-job.
        queue_job(0, 1, 1);
        @(posedge clk); #1;
        req = 2'b01;
        @(negedge clk);
        check("gnt_before_edge", gnt, 2'b00);
        @(negedge clk);
        check("gnt_after_edge", gnt, 2'b01);
        check("busy_in_job", busy, 1);
        check("in_ready_load", in_ready, 1);
        @(posedge clk); #1;
        req = 2'b00;
        wait_drain("basic_drain", 400);

        // Granted requester toggles valid; the other holds valid high throughout.
        gap0 = 1;
        for (int j = 0; j < SC; j++) src1.push_back(DW'(32'hDEAD0000 + j));
        queue_job(0, 100, 1);
        run_job(2'b01, "gaps");
        gap0 = 0;
        src1.delete();

        // Output backpressure at index 4 for three cycles.
        stall_k = 4;
        stall_left = 3;
        queue_job(1, 50, 1);
        run_job(2'b10, "stall");
        check("stall_consumed", stall_left, 0);
        stall_k = -1;

        // Both requesting continuously: grants alternate 0,1,0,1.
        queue_job(0, 400, 1);
        queue_job(1, 500, 1);
        queue_job(0, 600, 1);
        queue_job(1, 700, 1);
        n = grant_cnt;
        @(posedge clk); #1;
        req = 2'b11;
        for (int c = 0; c < 400 && grant_cnt < n + 4; c++) begin
            @(posedge clk); #2;
        end
        check("rr_grants", grant_cnt - n, 4);
        req = 2'b00;
        wait_drain("rr_drain", 400);

        // Datapath never finishes: one err pulse, no results.
        done_delay = 0;
        queue_job(0, 800, 0);
        run_job(2'b01, "timeout");
        check("err_pulses", err_cnt, 1);
        done_delay = 5;

        // Reset in LOAD at k=5, then a fresh job from requester 1.
        queue_job(0, 900, 1);
        @(posedge clk); #1;
        req = 2'b01;
        n = 0;
        while (!(gnt == 2'b01 && job_loads == 5) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("reached_k5", job_loads, 5);
        reset = 1'b1;
        req = 2'b00;
        @(posedge clk); #2;
        check_idle("midreset");
        exp_q.delete();
        src0.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        queue_job(1, 1000, 1);
        run_job(2'b10, "after_reset");
        check("err_total", err_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_job_sched.md
FIR_JOB_SCHED -- requirements
Module: fir_job_sched

Interface
REQ-001 The block SHALL have parameter SIGNAL_COUNT, default 10, the number of samples loaded and results read per job.
REQ-002 The block SHALL have parameter DATA_W, default 32, the sample and result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, the maximum COMPUTE cycles before abort.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  2  per-requester job request, req[i] for requester i.
REQ-007 gnt  output  2  one-hot grant; requester owning the datapath.
REQ-008 in_data0, in_data1  input  DATA_W each  sample data per requester.
REQ-009 in_valid  input  2  sample valid per requester.
REQ-010 in_ready  output  1  sample accept; applies to the granted requester only.
REQ-011 out_data  output  DATA_W  result sample.
REQ-012 out_valid, out_last, out_id  output  1 each  result valid, final result of job, owning requester index.
REQ-013 out_ready  input  1  result accept.
REQ-014 fir_op  output  2  datapath operation: 00 idle, 01 load, 10 compute, 11 readout.
REQ-015 fir_addr  output  32  datapath sample/result index.
REQ-016 fir_x, fir_load  output  DATA_W, 1  sample to datapath; write strobe.
REQ-017 fir_y, fir_done  input  DATA_W, 1  datapath result at fir_addr (combinational); datapath done.
REQ-018 busy, err  output  1 each  job in progress; one-cycle timeout pulse.

Function
REQ-019 States SHALL be IDLE, LOAD, COMPUTE, READ, RELEASE; fir_op SHALL be 00/01/10/11/00 respectively.
REQ-020 IDLE: any req bit high at edge t SHALL set gnt and enter LOAD at t+1 with index counter k=0; busy high from t+1 until the RELEASE cycle inclusive.
REQ-021 Arbitration SHALL be round-robin: single requester wins; both high -> the one not served last; after reset requester 0 wins a tie.
REQ-022 LOAD: in_ready SHALL be 1; a sample is accepted when in_valid[granted]=1; on accept fir_load=1, fir_x=in_data of granted requester, fir_addr=k, k increments.
REQ-023 LOAD with in_valid[granted]=0 SHALL stall: fir_load=0, k held, fir_op stays 01; in_valid of the non-granted requester SHALL be ignored.
REQ-024 Accept of sample k=SIGNAL_COUNT-1 SHALL move to COMPUTE next cycle; in_ready SHALL be 0 outside LOAD.
REQ-025 COMPUTE: fir_done=1 SHALL move to READ next cycle with k=0; a cycle counter SHALL count COMPUTE cycles.
REQ-026 COMPUTE lasting TIMEOUT cycles without fir_done SHALL pulse err for one cycle and go to RELEASE, producing no results.
REQ-027 READ: fir_addr=k, out_valid=1, out_data=fir_y, out_id=granted index, out_last=(k==SIGNAL_COUNT-1); k advances only on out_valid&&out_ready; out_data/out_id SHALL hold stable while stalled.
REQ-028 Handshake of the out_last result SHALL move to RELEASE.
REQ-029 RELEASE SHALL last exactly one cycle: gnt=00, fir_op=00, last-served updated to the job's requester, then IDLE; a pending req may be granted no earlier than the following IDLE cycle.
REQ-030 req deasserting during a job SHALL NOT abort it; the job completes.
REQ-031 fir_addr SHALL be 0 in IDLE, COMPUTE and RELEASE; fir_load SHALL be 0 outside LOAD.

Reset
REQ-032 reset=1 at any edge, in any state, SHALL force IDLE, gnt=00, fir_op=00, fir_addr=0, fir_x=0, fir_load=0, in_ready=0, out_valid=0, out_last=0, out_id=0, out_data=0, busy=0, err=0, k=0, timeout counter=0, last-served=1.
REQ-033 Reset mid-job SHALL discard the job; no result is emitted afterwards.

Verification
REQ-034 req=01, samples 1..10 streamed without gaps, fir_done 5 cycles after COMPUTE entry, out_ready=1 -> gnt=01 one cycle after req, 10 fir_load pulses addr 0..9, 10 results out_id=0, out_last on the 10th, RELEASE one cycle.
REQ-035 req=11 held continuously after reset -> jobs granted 0,1,0,1; each gnt preceded by one RELEASE cycle with gnt=00.
REQ-036 in_valid[granted] toggled 1,0,1,0 in LOAD; in_valid of other requester constantly 1 -> only granted samples written, k holds on gaps, exactly 10 fir_load pulses.
REQ-037 out_ready low 3 cycles at k=4 -> fir_addr=4, out_data stable for the stall, no result skipped or duplicated.
REQ-038 fir_done never asserted, TIMEOUT=16 -> err pulses on 16th COMPUTE cycle, RELEASE, IDLE, no out_valid.
REQ-039 reset asserted at k=5 in LOAD, then req=10 -> all outputs at reset values next cycle; requester 1 job starts with k=0.
